// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the frame FSM encoding, the vote sample offsets and small helper functions.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam int SMP_OFS_EARLY = -1;
  localparam int SMP_OFS_MID   = 0;
  localparam int SMP_OFS_LATE  = 1;

  localparam logic [3:0] DATA_LEN_MIN = 4'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    logic [3:0] res;
    if (len < DATA_LEN_MIN) begin
      res = DATA_LEN_MIN;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// Line synchroniser, per-bit edge counter and 3-sample majority vote.
// bit_o/vote_o are registered the cycle after the last of the three samples.
module uart_rx_cfg_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  rx_o,
  output logic                  bit_o,
  output logic                  vote_o,
  output logic                  wrap_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0]  half, smp_early, smp_mid, smp_late;
  logic [1:0]             smp_q, smp_d;
  logic                   bit_q, bit_d;
  logic                   vote_q, vote_d;
  logic                   rx;

  assign rx        = sync_q[SYNC_STAGES-1];
  assign half      = {1'b0, prescale_i[PRESCALE_W-1:1]};
  assign smp_early = half + PRESCALE_W'(SMP_OFS_EARLY);
  assign smp_mid   = half + PRESCALE_W'(SMP_OFS_MID);
  assign smp_late  = half + PRESCALE_W'(SMP_OFS_LATE);
  assign wrap_o    = en_i && (edge_cnt_q == (prescale_i - PRESCALE_W'(1)));
  assign rx_o      = rx;
  assign bit_o     = bit_q;
  assign vote_o    = vote_q;

  // Synchroniser chain, reset to the idle line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  // Edge counter and sample capture; the counter is held at zero while disabled.
  always_comb begin
    edge_cnt_d = '0;
    smp_d      = smp_q;
    bit_d      = bit_q;
    vote_d     = 1'b0;
    if (en_i) begin
      if (wrap_o) begin
        edge_cnt_d = '0;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      if (edge_cnt_q == smp_early) begin
        smp_d[0] = rx;
      end else if (edge_cnt_q == smp_mid) begin
        smp_d[1] = rx;
      end else if (edge_cnt_q == smp_late) begin
        bit_d  = maj3(smp_q[0], smp_q[1], rx);
        vote_d = 1'b1;
      end else begin
        smp_d = smp_q;
      end
    end else begin
      edge_cnt_d = '0;
    end
  end

  // Counter, sample and vote registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
      smp_q      <= 2'b11;
      bit_q      <= 1'b1;
      vote_q     <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      vote_q     <= vote_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: frame FSM, shift register, frame checks
// and a valid/ready holding register with overrun and break reporting.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int MAX_DATA_W  = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [MAX_DATA_W-1:0] P_DATA,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  OVR_ERR,
  output logic                  BRK_DET
);

  state_e                state_q, state_d;
  logic [3:0]            len_q, len_d, bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic                  par_bad_q, par_bad_d, par_bit_q, par_bit_d, stop_bad_q, stop_bad_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic                  ovr_err_q, ovr_err_d, brk_q, brk_d;
  logic                  rx_sync, vote_bit, vote_stb, wrap_stb, cnt_en, data_last, good;

  assign cnt_en    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign data_last = (bit_cnt_q == (len_q - 4'd1));
  assign good      = !stop_bad_q && !par_bad_q;

  uart_rx_cfg_sampler #(
    .PRESCALE_W (PRESCALE_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .rx_i      (RX_IN),
    .en_i      (cnt_en),
    .prescale_i(prescale_q),
    .rx_o      (rx_sync),
    .bit_o     (vote_bit),
    .vote_o    (vote_stb),
    .wrap_o    (wrap_stb)
  );

  // Frame state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop bits advance on the vote, not the wrap, to keep half a bit of margin.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rx_sync) state_d = ST_START; else state_d = ST_IDLE;
      ST_START:  if (vote_stb && vote_bit) state_d = ST_IDLE;
                 else if (wrap_stb) state_d = ST_DATA;
                 else state_d = ST_START;
      ST_DATA:   if (wrap_stb && data_last) state_d = par_en_q ? ST_PARITY : ST_STOP1;
                 else state_d = ST_DATA;
      ST_PARITY: if (wrap_stb) state_d = ST_STOP1; else state_d = ST_PARITY;
      ST_STOP1:  if (vote_stb) state_d = stop2_q ? ST_STOP2 : ST_DONE; else state_d = ST_STOP1;
      ST_STOP2:  if (vote_stb) state_d = ST_DONE; else state_d = ST_STOP2;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next-state: config latch, shifting, checks and frame outcome.
  always_comb begin
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    prescale_d = prescale_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_bad_d  = par_bad_q;
    par_bit_d  = par_bit_q;
    stop_bad_d = stop_bad_q;
    data_d     = data_q;
    valid_d    = valid_q & ~data_ready;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    ovr_err_d  = 1'b0;
    brk_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        len_d      = clamp_len(DATA_LEN, 4'(MAX_DATA_W));
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        stop2_d    = STOP2;
        prescale_d = Prescale;
        shift_d    = '0;
        bit_cnt_d  = 4'd0;
        par_bad_d  = 1'b0;
        par_bit_d  = 1'b0;
        stop_bad_d = 1'b0;
      end
      ST_DATA: begin
        // New bit lands at position len-1, so bits above the frame length stay zero.
        if (vote_stb) begin
          shift_d = {1'b0, shift_q[MAX_DATA_W-1:1]} | (MAX_DATA_W'(vote_bit) << (len_q - 4'd1));
        end else begin
          shift_d = shift_q;
        end
        if (wrap_stb) begin
          bit_cnt_d = data_last ? 4'd0 : bit_cnt_q + 4'd1;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_PARITY: begin
        if (vote_stb) begin
          par_bit_d = vote_bit;
          par_bad_d = vote_bit ^ (^shift_q) ^ par_typ_q;
        end else begin
          par_bit_d = par_bit_q;
        end
      end
      ST_STOP1, ST_STOP2: begin
        if (vote_stb && !vote_bit) begin
          stop_bad_d = 1'b1;
        end else begin
          stop_bad_d = stop_bad_q;
        end
      end
      ST_DONE: begin
        stp_err_d = stop_bad_q;
        brk_d     = stop_bad_q && (shift_q == '0) && !(par_en_q && par_bit_q);
        par_err_d = !stop_bad_q && par_bad_q;
        if (good) begin
          if (!valid_q || data_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_err_d = 1'b1;
            valid_d   = 1'b1;
          end
        end else begin
          data_d = data_q;
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q      <= DATA_LEN_MIN;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      prescale_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= 4'd0;
      par_bad_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      prescale_q <= prescale_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_bad_q  <= par_bad_d;
      par_bit_q  <= par_bit_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      ovr_err_q  <= ovr_err_d;
      brk_q      <= brk_d;
    end
  end

  assign P_DATA     = data_q;
  assign data_valid = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign OVR_ERR    = ovr_err_q;
  assign BRK_DET    = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg: frames are driven bit by bit and
// observed pulses/words are tallied by a negedge monitor, then compared to hand values.
module tb_uart_rx_cfg;
  import uart_rx_cfg_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [3:0] DATA_LEN = 4'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       PAR_ERR, STP_ERR, OVR_ERR, BRK_DET;

  int checks = 0;
  int errors = 0;

  int par_cnt = 0, stp_cnt = 0, ovr_cnt = 0, brk_cnt = 0, both_cnt = 0;
  int rise_cnt = 0, valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       valid_prev = 1'b0;
  int par_b, stp_b, ovr_b, brk_b, both_b, rise_b, vcyc_b;

  uart_rx_cfg dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .DATA_LEN  (DATA_LEN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .OVR_ERR   (OVR_ERR),
    .BRK_DET   (BRK_DET)
  );

  always #5 CLK = ~CLK;

  // Tally output pulses and newly presented words away from the active edge.
  always @(negedge CLK) begin
    if (PAR_ERR) par_cnt++;
    if (STP_ERR) stp_cnt++;
    if (OVR_ERR) ovr_cnt++;
    if (BRK_DET) brk_cnt++;
    if (STP_ERR && BRK_DET) both_cnt++;
    if (data_valid) valid_cyc++;
    if (data_valid && !valid_prev) begin
      rise_cnt++;
      last_data = P_DATA;
    end
    valid_prev = data_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] data, input int len, input bit pen,
                            input bit pbit, input int nstop, input int p);
    hold(1'b0, p);
    for (int i = 0; i < len; i++) hold(data[i], p);
    if (pen) hold(pbit, p);
    for (int i = 0; i < nstop; i++) hold(1'b1, p);
    hold(1'b1, 2 * p);
  endtask

  function automatic bit calc_par(input logic [8:0] data, input int len, input bit odd);
    bit x;
    x = odd;
    for (int i = 0; i < len; i++) x ^= data[i];
    return x;
  endfunction

  task automatic snap();
    par_b = par_cnt; stp_b = stp_cnt; ovr_b = ovr_cnt; brk_b = brk_cnt;
    both_b = both_cnt; rise_b = rise_cnt; vcyc_b = valid_cyc;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_pdata", P_DATA, 0);
    check_eq("rst_flags", {PAR_ERR, STP_ERR, OVR_ERR, BRK_DET}, 0);
    check_eq("rst_state", dut.state_q, ST_IDLE);
    RST = 1'b1;
    hold(1'b1, 16);

    // 8N1, Prescale 8
    snap();
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 8);
    check_eq("t1_data", last_data, 8'hA5);
    check_eq("t1_rise", rise_cnt - rise_b, 1);
    check_eq("t1_vcyc", valid_cyc - vcyc_b, 1);
    check_eq("t1_errs", (par_cnt - par_b) + (stp_cnt - stp_b) + (ovr_cnt - ovr_b) + (brk_cnt - brk_b), 0);
    check_eq("t1_valid_low", data_valid, 0);

    // 7E2, Prescale 16, wrong parity bit
    Prescale = 6'd16; DATA_LEN = 4'd7; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b1;
    snap();
    send_frame(9'h03C, 7, 1'b1, 1'b1, 2, 16);
    check_eq("t2_par", par_cnt - par_b, 1);
    check_eq("t2_stp", stp_cnt - stp_b, 0);
    check_eq("t2_rise", rise_cnt - rise_b, 0);

    // Short start glitch, then a good frame
    Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    snap();
    hold(1'b0, 2);
    hold(1'b1, 48);
    check_eq("t3_state", dut.state_q, ST_IDLE);
    check_eq("t3_rise", rise_cnt - rise_b, 0);
    check_eq("t3_errs", (par_cnt - par_b) + (stp_cnt - stp_b) + (brk_cnt - brk_b), 0);
    check_eq("t3_pdata_kept", P_DATA, 8'hA5);
    send_frame(9'h055, 8, 1'b0, 1'b0, 1, 8);
    check_eq("t3_data", last_data, 8'h55);
    check_eq("t3_rise2", rise_cnt - rise_b, 1);

    // Overrun with the consumer stalled
    data_ready = 1'b0;
    snap();
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 8);
    check_eq("t4_valid1", data_valid, 1);
    check_eq("t4_pdata1", P_DATA, 8'h11);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 8);
    check_eq("t4_ovr", ovr_cnt - ovr_b, 1);
    check_eq("t4_pdata2", P_DATA, 8'h11);
    check_eq("t4_rise", rise_cnt - rise_b, 1);
    data_ready = 1'b1;
    @(negedge CLK);
    check_eq("t4_valid_hs", data_valid, 1);
    @(negedge CLK);
    check_eq("t4_valid_drop", data_valid, 0);

    // Break: line low for 12 bit times
    snap();
    hold(1'b0, 12 * 8);
    hold(1'b1, 12 * 8 + 16);
    check_eq("t5_stp", stp_cnt - stp_b, 1);
    check_eq("t5_brk", brk_cnt - brk_b, 1);
    check_eq("t5_same_cycle", both_cnt - both_b, 1);
    check_eq("t5_par", par_cnt - par_b, 0);

    // One-clock low glitch on the centre sample of data bit 3, Prescale 16
    Prescale = 6'd16;
    data_ready = 1'b0;
    snap();
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        hold(1'b1, 9);
        hold(1'b0, 1);
        hold(1'b1, 6);
      end else begin
        hold(1'b1, 16);
      end
    end
    hold(1'b1, 16);
    hold(1'b1, 32);
    check_eq("t6_data", last_data, 8'hFF);
    check_eq("t6_rise", rise_cnt - rise_b, 1);
    check_eq("t6_valid", data_valid, 1);

    // Asynchronous reset in the middle of the data bits
    Prescale = 6'd8;
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 3);
    check_eq("t7_pre_state", dut.state_q, ST_DATA);
    #2;
    RST = 1'b0;
    #1;
    check_eq("t7_valid", data_valid, 0);
    check_eq("t7_pdata", P_DATA, 0);
    check_eq("t7_flags", {PAR_ERR, STP_ERR, OVR_ERR, BRK_DET}, 0);
    check_eq("t7_state", dut.state_q, ST_IDLE);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    data_ready = 1'b1;
    hold(1'b1, 16);

    // Out-of-range DATA_LEN clamps to 8; minimum Prescale of 6
    Prescale = 6'd6; DATA_LEN = 4'd15;
    snap();
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 6);
    check_eq("t8_data", last_data, 8'h3C);
    check_eq("t8_rise", rise_cnt - rise_b, 1);

    // 5-bit odd parity, correct parity bit
    Prescale = 6'd8; DATA_LEN = 4'd5; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    snap();
    send_frame(9'h016, 5, 1'b1, calc_par(9'h016, 5, 1'b1), 1, 8);
    check_eq("t9_data", last_data, 8'h16);
    check_eq("t9_par", par_cnt - par_b, 0);
    check_eq("t9_rise", rise_cnt - rise_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
